// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction cache address split and frame layout.
// Widths below are the default 16-frame geometry.
package cpu_types_pkg;

   localparam int ICACHE_IDX_W = 4;
   localparam int ICACHE_SETS  = 1 << ICACHE_IDX_W;
   localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

   typedef struct packed {
      logic [ICACHE_TAG_W-1:0] tag;
      logic [ICACHE_IDX_W-1:0] idx;
      logic [1:0]              bytoff;
   } icachef_t;

   typedef struct packed {
      logic                    valid;
      logic [ICACHE_TAG_W-1:0] tag;
      logic [31:0]             data;
   } icache_frame_t;

endpackage

// File: rtl/icache_if.sv
// Datapath fetch port and memory read port of the instruction cache.
// master = surrounding datapath/memory, slave = the cache.
interface icache_if;

   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        flush;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   modport master (
      output imemREN, imemaddr, flush, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );

   modport slave (
      input  imemREN, imemaddr, flush, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with IDLE/FILL miss FSM.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache
   import cpu_types_pkg::*;
#(
   parameter int SETS  = ICACHE_SETS,
   parameter int IDX_W = ICACHE_IDX_W
) (
   input  logic        CLK,
   input  logic        RST,
   icache_if.slave     bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {
      IDLE,
      FILL
   } icache_state_t;

   icache_state_t state;

   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tags  [SETS];
   logic [31:0]      words [SETS];

   logic [31:0]      miss_addr;
   logic             iren_q;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [IDX_W-1:0] fidx;
   logic [TAG_W-1:0] ftag;
   logic             hit;
   logic             miss;
   logic             fill_we;
   logic             unused_boff;

   assign idx  = bus.imemaddr[IDX_W+1:2];
   assign tag  = bus.imemaddr[31:IDX_W+2];
   assign fidx = miss_addr[IDX_W+1:2];
   assign ftag = miss_addr[31:IDX_W+2];

   assign unused_boff = ^bus.imemaddr[1:0];

   assign hit = (state == IDLE) && bus.imemREN && valid[idx]
             && (tags[idx] == tag) && !bus.flush;

   assign miss = (state == IDLE) && bus.imemREN && !hit && !bus.flush;

   // flush or reset in the completing cycle abandons the fill
   assign fill_we = (state == FILL) && !bus.iwait && !bus.flush && !RST;

   assign bus.ihit     = hit;
   assign bus.imemload = hit ? words[idx] : 32'h0;
   assign bus.iREN     = iren_q;
   assign bus.iaddr    = miss_addr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         valid     <= '0;
         miss_addr <= 32'h0;
         iren_q    <= 1'b0;
`ifdef ICACHE_STATS_EN
         hit_count  <= 32'h0;
         miss_count <= 32'h0;
`endif
      end else begin
         if (bus.flush)
            valid <= '0;
         case (state)
            IDLE: begin
               if (miss) begin
                  state     <= FILL;
                  miss_addr <= {bus.imemaddr[31:2], 2'b00};
                  iren_q    <= 1'b1;
               end
            end
            FILL: begin
               if (bus.flush || !bus.iwait) begin
                  state     <= IDLE;
                  miss_addr <= 32'h0;
                  iren_q    <= 1'b0;
               end
               if (fill_we)
                  valid[fidx] <= 1'b1;
            end
            default: state <= IDLE;
         endcase
`ifdef ICACHE_STATS_EN
         if (hit)
            hit_count <= hit_count + 32'd1;
         if (miss)
            miss_count <= miss_count + 32'd1;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (fill_we) begin
         tags[fidx]  <= ftag;
         words[fidx] <= bus.iload;
      end
   end

endmodule
